multicycle_ctrl: RTL and testbench

- Multicycle RV32I control unit. It sequences each instruction through fetch, decode, execute and writeback states and drives the datapath mux selects and write enables.
- It issues the 4-bit alu_ctrl codes consumed by the team's 32-bit ALU, so it is the issuing end of that ALU's control interface.
- It sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback
// and drives datapath selects, write enables and ALU control codes.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [3:0] alu_ctrl,
   output logic       instr_done,
   output logic       illegal
);

   localparam int OPW = 7;

   localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
   localparam logic [OPW-1:0] OP_STORE = 7'b0100011;
   localparam logic [OPW-1:0] OP_R     = 7'b0110011;
   localparam logic [OPW-1:0] OP_I     = 7'b0010011;
   localparam logic [OPW-1:0] OP_BR    = 7'b1100011;
   localparam logic [OPW-1:0] OP_JAL   = 7'b1101111;
   localparam logic [OPW-1:0] OP_JALR  = 7'b1100111;
   localparam logic [OPW-1:0] OP_LUI   = 7'b0110111;
   localparam logic [OPW-1:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH,
      S_JAL, S_JALR1, S_LUI, S_AUIPC
   } state_t;

   state_t state, state_nx;

   logic       pc_update;
   logic       branch;
   logic       taken;
   logic [3:0] alu_fn;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = S_FETCH;
      case (state)
         S_FETCH:  state_nx = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_nx = S_MEMADR;
               OP_R:     state_nx = S_EXECR;
               OP_I:     state_nx = S_EXECI;
               OP_BR:    state_nx = S_BRANCH;
               OP_JAL:   state_nx = S_JAL;
               OP_JALR:  state_nx = S_JALR1;
               OP_LUI:   state_nx = S_LUI;
               OP_AUIPC: state_nx = S_AUIPC;
               default:  state_nx = S_FETCH;
            endcase
         end
         S_MEMADR:
            state_nx = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_nx = S_MEMWB;
         S_EXECR:   state_nx = S_ALUWB;
         S_EXECI:   state_nx = S_ALUWB;
         S_JAL:     state_nx = S_ALUWB;
         S_JALR1:   state_nx = S_JAL;
         S_AUIPC:   state_nx = S_ALUWB;
         default:   state_nx = S_FETCH;
      endcase
   end

   // Shift-left immediate uses its own code; only R-type honours SUB
   always_comb begin
      alu_fn = 4'b0000;
      case (funct3)
         3'b000: alu_fn = (state == S_EXECR && funct7b5) ? 4'b0001 : 4'b0000;
         3'b001: alu_fn = (state == S_EXECR) ? 4'b1001 : 4'b0100;
         3'b010: alu_fn = 4'b0101;
         3'b011: alu_fn = 4'b0110;
         3'b100: alu_fn = 4'b0111;
         3'b101: alu_fn = funct7b5 ? 4'b1101 : 4'b1111;
         3'b110: alu_fn = 4'b0011;
         3'b111: alu_fn = 4'b0010;
         default: alu_fn = 4'b0000;
      endcase
   end

   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      taken      = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      imm_src    = 3'b000;
      alu_ctrl   = 4'b0000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            case (opcode)
               OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR,
               OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ;
               default: begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = (opcode == OP_LOAD) ? 3'b000 : 3'b001;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_ctrl  = alu_fn;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctrl  = alu_fn;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = 2'b10;
            alu_ctrl   = 4'b0001;
            branch     = 1'b1;
            instr_done = 1'b1;
            case (funct3)
               3'b000:  taken = zero;
               3'b001:  taken = ~zero;
               default: illegal = 1'b1;
            endcase
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_JALR1: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_LUI: begin
            imm_src    = 3'b100;
            result_src = 2'b11;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 3'b100;
         end
         default: ;
      endcase
      pc_write = pc_update | (branch & taken);
      // No architectural side effects in a reset cycle
      if (reset) begin
         pc_write   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class
// state by state against hand-built control words.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_src;
   logic [3:0] alu_ctrl;
   logic       instr_done, illegal;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write),
      .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [19:0] outv;
   logic [5:0]  env;
   assign outv = {pc_write, adr_src, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl,
                  instr_done, illegal};
   assign env = {pc_write, mem_write, ir_write, reg_write,
                 instr_done, illegal};

   function automatic logic [19:0] v(
      input logic pcw, adr, mw, irw, rw,
      input logic [1:0] rs, sa, sb,
      input logic [2:0] imm,
      input logic [3:0] alu,
      input logic dn, il);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, dn, il};
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge; compares, then moves one cycle on
   task automatic cyc(input string tag, input logic [19:0] exp);
      #1 check(tag, {12'd0, outv}, {12'd0, exp});
      @(negedge clk);
   endtask

   task automatic set(input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic z);
      opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   logic [19:0] FETCH, DEC_B, DEC_J, ALUWB, JALS;
   initial begin
      FETCH = v(1,0,0,1,0, 2'b10,2'b00,2'b10, 3'b000,4'b0000, 0,0);
      DEC_B = v(0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b010,4'b0000, 0,0);
      DEC_J = v(0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b011,4'b0000, 0,0);
      ALUWB = v(0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 1,0);
      JALS  = v(1,0,0,0,0, 2'b00,2'b01,2'b10, 3'b000,4'b0000, 0,0);
   end

   initial begin
      reset = 1'b1;
      set(7'b0110011, 3'b000, 1'b1, 1'b0);
      repeat (2) begin
         @(negedge clk);
         #1 check("rst_en", {26'd0, env}, 32'd0);
      end
      reset = 1'b0;

      // R-type SUB then SRL
      cyc("r_sub_fetch", FETCH);
      cyc("r_sub_dec", DEC_B);
      cyc("r_sub_ex", v(0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,4'b0001, 0,0));
      cyc("r_sub_wb", ALUWB);
      set(7'b0110011, 3'b101, 1'b0, 1'b0);
      cyc("r_srl_fetch", FETCH);
      cyc("r_srl_dec", DEC_B);
      cyc("r_srl_ex", v(0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,4'b1111, 0,0));
      cyc("r_srl_wb", ALUWB);

      // I-type SRAI then SLLI
      set(7'b0010011, 3'b101, 1'b1, 1'b0);
      cyc("i_srai_fetch", FETCH);
      cyc("i_srai_dec", DEC_B);
      cyc("i_srai_ex", v(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000,4'b1101, 0,0));
      cyc("i_srai_wb", ALUWB);
      set(7'b0010011, 3'b001, 1'b0, 1'b0);
      cyc("i_slli_fetch", FETCH);
      cyc("i_slli_dec", DEC_B);
      cyc("i_slli_ex", v(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000,4'b0100, 0,0));
      cyc("i_slli_wb", ALUWB);

      // Load, store
      set(7'b0000011, 3'b010, 1'b0, 1'b0);
      cyc("ld_fetch", FETCH);
      cyc("ld_dec", DEC_B);
      cyc("ld_adr", v(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000,4'b0000, 0,0));
      cyc("ld_rd", v(0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 0,0));
      cyc("ld_wb", v(0,0,0,0,1, 2'b01,2'b00,2'b00, 3'b000,4'b0000, 1,0));
      set(7'b0100011, 3'b010, 1'b0, 1'b0);
      cyc("st_fetch", FETCH);
      cyc("st_dec", DEC_B);
      cyc("st_adr", v(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b001,4'b0000, 0,0));
      cyc("st_wr", v(0,1,1,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 1,0));

      // Branches: BEQ taken, BNE not taken, unsupported funct3
      set(7'b1100011, 3'b000, 1'b0, 1'b1);
      cyc("beq_fetch", FETCH);
      cyc("beq_dec", DEC_B);
      cyc("beq_br", v(1,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,4'b0001, 1,0));
      set(7'b1100011, 3'b001, 1'b0, 1'b1);
      cyc("bne_fetch", FETCH);
      cyc("bne_dec", DEC_B);
      cyc("bne_br", v(0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,4'b0001, 1,0));
      set(7'b1100011, 3'b100, 1'b0, 1'b1);
      cyc("bbad_fetch", FETCH);
      cyc("bbad_dec", DEC_B);
      cyc("bbad_br", v(0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000,4'b0001, 1,1));

      // JAL, JALR
      set(7'b1101111, 3'b000, 1'b0, 1'b0);
      cyc("jal_fetch", FETCH);
      cyc("jal_dec", DEC_J);
      cyc("jal_jal", JALS);
      cyc("jal_wb", ALUWB);
      set(7'b1100111, 3'b000, 1'b0, 1'b0);
      cyc("jalr_fetch", FETCH);
      cyc("jalr_dec", DEC_B);
      cyc("jalr_1", v(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000,4'b0000, 0,0));
      cyc("jalr_jal", JALS);
      cyc("jalr_wb", ALUWB);

      // LUI, AUIPC
      set(7'b0110111, 3'b000, 1'b0, 1'b0);
      cyc("lui_fetch", FETCH);
      cyc("lui_dec", DEC_B);
      cyc("lui_lui", v(0,0,0,0,1, 2'b11,2'b00,2'b00, 3'b100,4'b0000, 1,0));
      set(7'b0010111, 3'b000, 1'b0, 1'b0);
      cyc("auipc_fetch", FETCH);
      cyc("auipc_dec", DEC_B);
      cyc("auipc_ex", v(0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b100,4'b0000, 0,0));
      cyc("auipc_wb", ALUWB);

      // Illegal opcode
      set(7'b1111111, 3'b000, 1'b0, 1'b0);
      cyc("ill_fetch", FETCH);
      cyc("ill_dec", v(0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b010,4'b0000, 1,1));

      // Reset landing in MEMWB must suppress the register write
      set(7'b0000011, 3'b010, 1'b0, 1'b0);
      cyc("ldr_fetch", FETCH);
      cyc("ldr_dec", DEC_B);
      cyc("ldr_adr", v(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000,4'b0000, 0,0));
      cyc("ldr_rd", v(0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 0,0));
      reset = 1'b1;
      #1 check("ldr_rst_en", {26'd0, env}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc("post_rst_fetch", FETCH);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
